// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from ID/EX/MEM and stall/flush controls back to the pipeline
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_write_addr;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_write;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_reg_write,
               ex_write_addr, ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
               mem_error, stall_cycles, flush_events
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_reg_write,
               ex_write_addr, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
               mem_error, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for load-use, branch/jump redirects and timed memory waits
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                  clock,
    input logic                  reset,
    pipeline_hazard_ctrl_if.master hz
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state, state_next;
    logic [WW-1:0] wait_cnt, wait_next;
    logic          frozen, timeout, load_use;

    assign load_use = hz.ex_mem_read && (hz.ex_write_addr != 5'd0) &&
                      (hz.ex_write_addr == hz.id_rs ||
                       (hz.id_uses_rt && hz.ex_write_addr == hz.id_rt));
    assign timeout  = state == MEM_WAIT && !hz.mem_ready && wait_cnt >= WW'(MEM_TIMEOUT);
    assign frozen   = state == RUN ? hz.mem_req && !hz.mem_ready
                                   : !hz.mem_ready && !timeout;

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.exmem_write = 1'b1;
        if (reset) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
        end else if (frozen) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.exmem_write = 1'b0;
        end else if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
        end else if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_flush  = 1'b1;
        end else if (hz.id_jump) begin
            hz.ifid_flush  = 1'b1;
        end
    end

    // a release (ready or timeout) always returns to RUN; a frozen wait just counts
    always_comb begin
        state_next = RUN;
        wait_next  = '0;
        if (state == RUN && frozen) begin
            state_next = MEM_WAIT;
            wait_next  = WW'(1);
        end else if (state == MEM_WAIT && frozen) begin
            state_next = MEM_WAIT;
            wait_next  = wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= '0;
            hz.mem_error    <= 1'b0;
            hz.stall_cycles <= '0;
            hz.flush_events <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (timeout)
                hz.mem_error <= 1'b1;
            if (!hz.pc_write && hz.stall_cycles != {CNT_W{1'b1}})
                hz.stall_cycles <= hz.stall_cycles + CNT_W'(1);
            if ((hz.ifid_flush || hz.idex_flush) && hz.flush_events != {CNT_W{1'b1}})
                hz.flush_events <= hz.flush_events + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed expectations
module tb_pipeline_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst4  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
        .clock (clock),
        .reset (rst4),
        .hz    (hz4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0; hz.id_jump = 1'b0;
        hz.ex_mem_read = 1'b0; hz.ex_reg_write = 1'b0; hz.ex_write_addr = 5'd0;
        hz.ex_branch_taken = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic ctrl(input string tag, input logic [4:0] exp);
        check({tag, "_ctrl"}, {27'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush,
                                hz.idex_flush, hz.exmem_write}, {27'd0, exp});
    endtask

    initial begin
        int n;
        idle();
        hz4.id_rs = 5'd8; hz4.id_rt = 5'd0; hz4.id_uses_rt = 1'b0; hz4.id_jump = 1'b0;
        hz4.ex_mem_read = 1'b1; hz4.ex_reg_write = 1'b1; hz4.ex_write_addr = 5'd8;
        hz4.ex_branch_taken = 1'b0; hz4.mem_req = 1'b0; hz4.mem_ready = 1'b0;

        // control vector order: pc_write, ifid_write, ifid_flush, idex_flush, exmem_write
        step(); step();
        ctrl("reset", 5'b00110);
        check("reset_stall", hz.stall_cycles, 0);
        check("reset_flush", hz.flush_events, 0);
        check("reset_err", hz.mem_error, 0);
        reset = 1'b0; #1;
        ctrl("run_idle", 5'b11001);
        step();
        check("idle_stall", hz.stall_cycles, 0);

        hz.ex_mem_read = 1'b1; hz.ex_write_addr = 5'd8; hz.id_rs = 5'd8; #1;
        ctrl("load_use_rs", 5'b00011);
        step(); idle(); #1;
        ctrl("after_bubble", 5'b11001);
        check("lu_stall", hz.stall_cycles, 1);
        check("lu_flush", hz.flush_events, 1);

        hz.ex_mem_read = 1'b1; hz.ex_write_addr = 5'd0; hz.id_rs = 5'd0; #1;
        ctrl("load_r0", 5'b11001);
        step(); idle();

        hz.ex_mem_read = 1'b1; hz.ex_write_addr = 5'd9; hz.id_rt = 5'd9; hz.id_rs = 5'd1; #1;
        ctrl("rt_unused", 5'b11001);
        hz.id_uses_rt = 1'b1; #1;
        ctrl("rt_used", 5'b00011);
        step(); idle(); #1;
        check("rt_stall", hz.stall_cycles, 2);
        check("rt_flush", hz.flush_events, 2);

        hz.ex_mem_read = 1'b1; hz.ex_write_addr = 5'd8; hz.id_rs = 5'd8; hz.ex_branch_taken = 1'b1;
        hz.id_jump = 1'b1; #1;
        ctrl("branch_lu_jump", 5'b11111);
        step(); idle();
        hz.id_jump = 1'b1; #1;
        ctrl("jump", 5'b11101);
        step(); idle(); #1;
        check("br_j_stall", hz.stall_cycles, 2);
        check("br_j_flush", hz.flush_events, 4);

        hz.mem_req = 1'b1; hz.mem_ready = 1'b0; #1;
        ctrl("mem_freeze1", 5'b00000);
        step(); #1;
        ctrl("mem_freeze2", 5'b00000);
        step(); #1;
        ctrl("mem_freeze3", 5'b00000);
        step();
        hz.mem_ready = 1'b1; #1;
        ctrl("mem_release", 5'b11001);
        step(); idle(); #1;
        ctrl("mem_after", 5'b11001);
        check("mem_stall", hz.stall_cycles, 5);
        check("mem_err0", hz.mem_error, 0);

        hz.mem_req = 1'b1; hz.mem_ready = 1'b0; #1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (!hz.pc_write && !hz.exmem_write) n++;
            step();
        end
        check("timeout_frozen", n, 16);
        ctrl("timeout_release", 5'b11001);
        step(); idle(); #1;
        check("timeout_err", hz.mem_error, 1);
        check("timeout_stall", hz.stall_cycles, 21);
        ctrl("timeout_run", 5'b11001);
        step(); step();
        check("err_sticky", hz.mem_error, 1);

        reset = 1'b1; step(); reset = 1'b0; #1;
        check("rst_err", hz.mem_error, 0);
        check("rst_stall", hz.stall_cycles, 0);
        check("rst_flush", hz.flush_events, 0);

        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        step(); step();
        reset = 1'b1; #1;
        ctrl("rst_in_wait", 5'b00110);
        step(); reset = 1'b0; idle(); #1;
        ctrl("run_after_rst", 5'b11001);
        step();
        check("rst_wait_stall", hz.stall_cycles, 0);

        rst4 = 1'b0;
        repeat (20) step();
        check("sat_stall", hz4.stall_cycles, 15);
        check("sat_flush", hz4.flush_events, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
